// File: rtl/rcon_seq_gen.sv
// AES round-constant sequencer: walks rcon forward (xtime) or backward (GF halving), 1-cycle registered latency.
// Backpressure: i_adv is ignored unless o_valid=1; optional RCON_SEQ_WRAP_EN reloads the start value instead of stopping.
module rcon_seq_gen #(
    parameter int WORD_W   = 32,
    parameter int BYTE_POS = WORD_W/8-1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_key_len,
    input  logic              i_dir,
    input  logic              i_adv,
    output logic [WORD_W-1:0] o_rcon,
    output logic [3:0]        o_idx,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] r_state, w_state_nxt;
    logic [7:0] r_rc, w_rc_nxt;
    logic [3:0] r_idx, w_idx_nxt;
    logic       r_last, w_last_nxt;
    logic [1:0] r_klen, w_klen_nxt;
    logic       r_dir, w_dir_nxt;

    logic [1:0] w_klen_in;
    logic [3:0] w_top;
    logic [7:0] w_fwd_rc;
    logic [7:0] w_rev_rc;

    function automatic logic [3:0] f_last_idx(input logic [1:0] klen);
        case (klen)
            2'b01:   f_last_idx = 4'd7;
            2'b10:   f_last_idx = 4'd6;
            default: f_last_idx = 4'd9;
        endcase
    endfunction

    function automatic logic [7:0] f_final_rc(input logic [1:0] klen);
        case (klen)
            2'b01:   f_final_rc = 8'h80;
            2'b10:   f_final_rc = 8'h40;
            default: f_final_rc = 8'h36;
        endcase
    endfunction

    always_comb begin
        w_klen_in   = (i_key_len == 2'b11) ? 2'b00 : i_key_len;
        w_top       = f_last_idx(r_klen);
        w_fwd_rc    = {r_rc[6:0], 1'b0} ^ (r_rc[7] ? 8'h1b : 8'h00);
        w_rev_rc    = r_rc[0] ? (((r_rc ^ 8'h1b) >> 1) | 8'h80) : (r_rc >> 1);
        w_state_nxt = r_state;
        w_rc_nxt    = r_rc;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_klen_nxt  = r_klen;
        w_dir_nxt   = r_dir;
        if (i_start) begin
            // start takes priority over a coincident advance
            w_state_nxt = S_RUN;
            w_klen_nxt  = w_klen_in;
            w_dir_nxt   = i_dir;
            w_rc_nxt    = i_dir ? f_final_rc(w_klen_in) : 8'h01;
            w_idx_nxt   = i_dir ? f_last_idx(w_klen_in) : 4'd0;
            w_last_nxt  = 1'b0;
        end else if (r_state == S_RUN && i_adv) begin
            if (r_last) begin
`ifdef RCON_SEQ_WRAP_EN
                w_rc_nxt    = r_dir ? f_final_rc(r_klen) : 8'h01;
                w_idx_nxt   = r_dir ? w_top : 4'd0;
                w_last_nxt  = 1'b0;
`else
                w_state_nxt = S_DONE;
                w_last_nxt  = 1'b0;
`endif
            end else if (!r_dir) begin
                w_rc_nxt   = w_fwd_rc;
                w_idx_nxt  = r_idx + 4'd1;
                w_last_nxt = ((r_idx + 4'd1) == w_top);
            end else begin
                w_rc_nxt   = w_rev_rc;
                w_idx_nxt  = r_idx - 4'd1;
                w_last_nxt = (r_idx == 4'd1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_rc    <= 8'h00;
            r_idx   <= 4'd0;
            r_last  <= 1'b0;
            r_klen  <= 2'b00;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rc    <= w_rc_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_klen  <= w_klen_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        o_rcon = '0;
        o_rcon[BYTE_POS*8 +: 8] = r_rc;
    end

    assign o_idx   = r_idx;
    assign o_valid = (r_state == S_RUN);
    assign o_busy  = (r_state == S_RUN);
    assign o_last  = r_last;

endmodule

// File: tb/tb_rcon_seq_gen.sv
// Bench for rcon_seq_gen: directed plan steps plus random traffic against a list-based rcon model.
module tb_rcon_seq_gen;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_key_len = 2'b00;
    logic        i_dir = 1'b0;
    logic        i_adv = 1'b0;
    logic [31:0] o_rcon;
    logic [3:0]  o_idx;
    logic        o_valid;
    logic        o_last;
    logic        o_busy;

    int total = 0;
    int bad   = 0;

    bit m_started = 0;
    bit m_run     = 0;
    bit m_dir     = 0;
    int m_n       = 10;
    int m_pos     = 0;

    rcon_seq_gen dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_key_len(i_key_len),
        .i_dir    (i_dir),
        .i_adv    (i_adv),
        .o_rcon   (o_rcon),
        .o_idx    (o_idx),
        .o_valid  (o_valid),
        .o_last   (o_last),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic int n_of(input logic [1:0] k);
        case (k)
            2'b01:   return 8;
            2'b10:   return 7;
            default: return 10;
        endcase
    endfunction

    // k-th AES round constant by repeated multiply-by-2 modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] nth_rc(input int k);
        int v = 1;
        for (int i = 0; i < k; i++) begin
            v = v * 2;
            if (v >= 256) v = v ^ 32'h11b;
        end
        return v[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int idx;
        idx = m_dir ? (m_n - 1 - m_pos) : m_pos;
        chk({tag, ".rcon"},  o_rcon,  m_started ? {nth_rc(idx), 24'h0} : 32'h0);
        chk({tag, ".idx"},   {28'h0, o_idx}, m_started ? 32'(idx) : 32'h0);
        chk({tag, ".valid"}, {31'h0, o_valid}, {31'h0, m_run});
        chk({tag, ".busy"},  {31'h0, o_busy},  {31'h0, m_run});
        chk({tag, ".last"},  {31'h0, o_last},  {31'h0, (m_run && m_pos == m_n - 1)});
    endtask

    task automatic cyc(input string tag, input bit s, input logic [1:0] k, input bit d, input bit a);
        i_start = s; i_key_len = k; i_dir = d; i_adv = a;
        @(posedge i_clk);
        if (s) begin
            m_started = 1; m_run = 1; m_dir = d; m_n = n_of(k); m_pos = 0;
        end else if (m_run && a) begin
            if (m_pos == m_n - 1) begin
`ifdef RCON_SEQ_WRAP_EN
                m_pos = 0;
`else
                m_run = 0;
`endif
            end else begin
                m_pos++;
            end
        end
        #1;
        i_start = 1'b0; i_adv = 1'b0;
        check_model(tag);
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst.rcon", o_rcon, 32'h0);
        chk("rst.valid", {31'h0, o_valid}, 32'h0);
        check_model("rst");
        i_rst_n = 1'b1;
        cyc("idle_adv", 0, 2'b00, 0, 1);

        cyc("f128.start", 1, 2'b00, 0, 0);
        chk("f128.first", o_rcon, 32'h0100_0000);
        for (int i = 0; i < 10; i++) begin
            cyc("f128.adv", 0, 2'b00, 0, 1);
            if (i == 8) chk("f128.final", o_rcon, 32'h3600_0000);
        end
        cyc("f128.done_adv", 0, 2'b00, 0, 1);

        cyc("r128.start", 1, 2'b00, 1, 0);
        chk("r128.first", o_rcon, 32'h3600_0000);
        for (int i = 0; i < 10; i++) cyc("r128.adv", 0, 2'b00, 1, 1);

        cyc("f192.start", 1, 2'b01, 0, 0);
        for (int i = 0; i < 8; i++) cyc("f192.adv", 0, 2'b01, 0, 1);
        cyc("r256.start", 1, 2'b10, 1, 0);
        chk("r256.first", o_rcon, 32'h4000_0000);
        for (int i = 0; i < 7; i++) cyc("r256.adv", 0, 2'b10, 1, 1);
        cyc("k11.start", 1, 2'b11, 0, 0);
        for (int i = 0; i < 10; i++) cyc("k11.adv", 0, 2'b11, 0, 1);

        cyc("rs.start", 1, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) cyc("rs.adv", 0, 2'b01, 1, 1);
        cyc("rs.restart", 1, 2'b00, 1, 1);
        chk("rs.rcon", o_rcon, 32'h3600_0000);
        chk("rs.idx", {28'h0, o_idx}, 32'd9);

        cyc("ar.start", 1, 2'b00, 0, 0);
        for (int i = 0; i < 5; i++) cyc("ar.adv", 0, 2'b00, 0, 1);
        #2 i_rst_n = 1'b0;
        #1;
        m_started = 0; m_run = 0; m_pos = 0; m_dir = 0; m_n = 10;
        chk("ar.rcon", o_rcon, 32'h0);
        chk("ar.valid", {31'h0, o_valid}, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc("ar.post_adv", 0, 2'b00, 0, 1);

        cyc("w256.start", 1, 2'b10, 0, 0);
        for (int i = 0; i < 8; i++) cyc("w256.adv", 0, 2'b10, 0, 1);

        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 11) == 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rcon_seq_gen.md
Name: rcon_seq_gen

Overview:
- Sequential AES round-constant generator for the on-the-fly key-expansion datapath.
- Supports AES-128/192/256 round counts.
- Steps forward for encryption key schedules, or backward from the final constant for decryption (inverse) key schedules.
- Computes each constant by GF(2^8) doubling or halving instead of a fixed lookup, with a start/advance handshake to the key-expansion controller.

Parameters:
- WORD_W, 32: output word width; must be a multiple of 8 and at least 8.
- BYTE_POS, WORD_W/8-1: byte lane of o_rcon that carries the constant; all other lanes are zero. Byte 3 gives {rc,24'h0}.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_start  in  1  one-cycle pulse; loads the first constant of a new sequence.
- i_key_len  in  2  00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved (treated as 00). Sampled on i_start.
- i_dir  in  1  0 = forward (0x01 upward), 1 = reverse (final constant downward). Sampled on i_start.
- i_adv  in  1  advance to the next constant; honoured only while o_valid=1.
- o_rcon  out  WORD_W  current round constant, placed in byte lane BYTE_POS.
- o_idx  out  4  index of the current constant in forward numbering (0-based).
- o_valid  out  1  o_rcon/o_idx hold a live constant.
- o_last  out  1  current constant is the final one in the direction of travel.
- o_busy  out  1  high in RUN state.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; o_rcon=0, o_idx=0, o_valid=0, o_last=0, o_busy=0. Latched key_len and dir are cleared to 0.
- Count N of constants: AES-128 = 10, AES-192 = 8, AES-256 = 7.
- States:
  - IDLE -> RUN on i_start.
  - RUN -> DONE on i_adv while o_last=1.
  - RUN -> RUN on i_start (restart).
  - DONE -> RUN on i_start.
  - i_adv is ignored in IDLE and DONE.
- Start, registered with 1-cycle latency:
  - Cycle after i_start: o_valid=1, o_busy=1.
  - Forward: rc=0x01, o_idx=0.
  - Reverse: rc = final constant, o_idx=N-1. Final constants: 0x36 (idx 9), 0x80 (idx 7), 0x40 (idx 6).
- Advance, registered with 1-cycle latency, taken when i_adv=1 in RUN with o_last=0:
  - Forward: rc <= xtime(rc) = (rc<<1) ^ (rc[7] ? 0x1b : 0); o_idx+1.
  - Reverse: rc <= rc[0] ? (((rc^0x1b)>>1) | 0x80) : (rc>>1); o_idx-1.
- o_last is a registered function of the next state:
  - Forward: 1 when o_idx==N-1.
  - Reverse: 1 when o_idx==0.
- Advance at o_last=1 (no wrap, see optional feature):
  - Next cycle: state=DONE, o_valid=0, o_last=0, o_busy=0.
  - o_rcon and o_idx hold their last values.
- i_start and i_adv in the same cycle: i_start wins and the sequence restarts with the newly sampled i_key_len/i_dir.
- i_key_len/i_dir changes outside an i_start cycle have no effect on a running sequence.
- i_adv held high advances one step per cycle. Back-to-back advance is supported with no bubble.
- Reset asserted mid-sequence: all outputs clear immediately (asynchronously). A new i_start is required afterwards.

Optional Feature:
- Macro: RCON_SEQ_WRAP_EN.
- Defined: advancing at o_last=1 does not enter DONE. The sequence reloads its start value (forward 0x01/idx 0; reverse final constant/idx N-1) on the next cycle with o_valid staying 1. This supports cyclic key regeneration; DONE is unreachable.
- Undefined: behaviour exactly as in Behaviour.

Test Plan:
- Reset, then i_start with key_len=00, dir=0, then i_adv held high 10 cycles:
  - Outputs run 0x01,02,04,08,10,20,40,80,1b,36 at byte 3, idx 0..9.
  - o_last=1 only on 0x36.
  - Then o_valid=0 and o_busy=0.
- key_len=00, dir=1, i_adv continuous:
  - Outputs 0x36,1b,80,40,20,10,08,04,02,01 with idx 9..0.
  - o_last only on 0x01.
- key_len=01 forward -> 8 constants ending at 0x80/idx 7. key_len=10 reverse -> starts at 0x40/idx 6. key_len=11 -> identical to 00.
- i_start together with i_adv mid-sequence (at idx 4, dir changed to 1, key_len=00) -> next cycle o_rcon=0x36, o_idx=9, o_valid=1.
- Reset pulsed low at idx 5 -> o_rcon=0 and o_valid=0 asynchronously. i_adv afterwards -> no change until i_start.
- With RCON_SEQ_WRAP_EN, key_len=10 forward, 8 advances -> 0x40 is followed by 0x01/idx 0 with o_valid continuously 1. Without the macro, the same stimulus -> DONE after 0x40.
